// File: rtl/mac_accumulate_stage.sv
// mac_accumulate_stage: accumulator stage behind the 8x8 multiplier tree.
// Sums LEN consecutive unsigned products and presents each sum on a held
// valid/ready output, together with an overflow flag. Wraps or saturates,
// depending on SAT.
//   clk, rst      rising-edge clock, synchronous active-high reset
//   clear         synchronous abort; drops any partial or held result
//   prod_in/prod_valid/prod_ready   product input handshake
//   acc_out/acc_valid/acc_ready     result output handshake
//   ovf           result overflowed ACC_W; qualified by acc_valid
//   busy          a partial sum is in progress
module mac_accumulate_stage #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN    = 8,
  parameter int unsigned SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               prod_ready_q, prod_ready_d;
  logic               acc_valid_q, acc_valid_d;
  logic               busy_q, busy_d;

  logic               in_xfer;
  logic               out_xfer;
  logic [SUM_W-1:0]   sum;
  logic               carry;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_xfer  = prod_valid & prod_ready_q;
  assign out_xfer = acc_valid_q & acc_ready;

  // One extra bit so the carry out of ACC_W is visible.
  assign sum     = SUM_W'(acc_q) + SUM_W'(prod_in);
  assign carry   = sum[ACC_W];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, datapath and decoded-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            acc_d   = ACC_W'(prod_in);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (LEN == 1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_xfer) begin
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
            // Once clamped, the sum stays at all-ones for the remaining terms.
            if ((SAT != 0) && (carry || ovf_q)) begin
              acc_d = '1;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
            if (cnt_inc == CNT_W'(LEN)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_xfer) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Handshake and status flags follow the state they will sit beside.
    prod_ready_d = (state_d != S_DONE);
    acc_valid_d  = (state_d == S_DONE);
    busy_d       = (state_d == S_ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b1;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      acc_valid_q  <= acc_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign acc_out    = acc_q;
  assign acc_valid  = acc_valid_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// tb_mac_accumulate_stage: drives five differently-parameterised copies of
// mac_accumulate_stage from one shared input bus.
//   a: LEN=4, ACC_W=24 wrap     b: LEN=8, ACC_W=24 wrap
//   c: LEN=4, ACC_W=17 wrap     d: LEN=4, ACC_W=17 saturate
//   e: LEN=1, ACC_W=24 wrap
module tb_mac_accumulate_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        acc_ready;

  logic        a_ready, a_valid, a_ovf, a_busy;
  logic [23:0] a_out;
  logic        b_ready, b_valid, b_ovf, b_busy;
  logic [23:0] b_out;
  logic        c_ready, c_valid, c_ovf, c_busy;
  logic [16:0] c_out;
  logic        d_ready, d_valid, d_ovf, d_busy;
  logic [16:0] d_out;
  logic        e_ready, e_valid, e_ovf, e_busy;
  logic [23:0] e_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulate_stage #(.PROD_W(16), .ACC_W(24), .LEN(4), .SAT(0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(a_ready), .acc_out(a_out), .acc_valid(a_valid), .acc_ready(acc_ready),
    .ovf(a_ovf), .busy(a_busy));
  mac_accumulate_stage #(.PROD_W(16), .ACC_W(24), .LEN(8), .SAT(0)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(b_ready), .acc_out(b_out), .acc_valid(b_valid), .acc_ready(acc_ready),
    .ovf(b_ovf), .busy(b_busy));
  mac_accumulate_stage #(.PROD_W(16), .ACC_W(17), .LEN(4), .SAT(0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(c_ready), .acc_out(c_out), .acc_valid(c_valid), .acc_ready(acc_ready),
    .ovf(c_ovf), .busy(c_busy));
  mac_accumulate_stage #(.PROD_W(16), .ACC_W(17), .LEN(4), .SAT(1)) u_d (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(d_ready), .acc_out(d_out), .acc_valid(d_valid), .acc_ready(acc_ready),
    .ovf(d_ovf), .busy(d_busy));
  mac_accumulate_stage #(.PROD_W(16), .ACC_W(24), .LEN(1), .SAT(0)) u_e (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(e_ready), .acc_out(e_out), .acc_valid(e_valid), .acc_ready(acc_ready),
    .ovf(e_ovf), .busy(e_busy));

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear      = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    acc_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_valid, a_ready, a_ovf, a_busy} !== 4'b0100) begin
      errors++; $display("FAIL reset_a_flags got %b exp 0100", {a_valid, a_ready, a_ovf, a_busy});
    end
    checks++;
    if (a_out !== 24'h0) begin
      errors++; $display("FAIL reset_a_out got %h exp 000000", a_out);
    end
    checks++;
    if ({c_valid, c_ready, c_ovf, c_busy, d_valid, d_ready, d_ovf, d_busy} !== 8'b0100_0100) begin
      errors++; $display("FAIL reset_cd_flags got %b exp 01000100",
                         {c_valid, c_ready, c_ovf, c_busy, d_valid, d_ready, d_ovf, d_busy});
    end
    checks++;
    if ({e_valid, e_ready, e_ovf, e_busy} !== 4'b0100) begin
      errors++; $display("FAIL reset_e_flags got %b exp 0100", {e_valid, e_ready, e_ovf, e_busy});
    end
  endtask

  task automatic test_basic_sum();
    do_reset();
    prod_valid = 1'b1;
    prod_in    = 16'h00E1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_valid !== 1'b0) begin
        errors++; $display("FAIL basic_early_valid xfers %0d got %b exp 0", i, a_valid);
      end
      step();
    end
    prod_valid = 1'b0;
    checks++;
    if ({a_valid, a_ready, a_ovf} !== 3'b100) begin
      errors++; $display("FAIL basic_flags got %b exp 100", {a_valid, a_ready, a_ovf});
    end
    checks++;
    if (a_out !== 24'h000384) begin
      errors++; $display("FAIL basic_sum got %h exp 000384", a_out);
    end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    checks++;
    if ({a_valid, a_ready, a_busy} !== 3'b010) begin
      errors++; $display("FAIL basic_return_idle got %b exp 010", {a_valid, a_ready, a_busy});
    end
  endtask

  task automatic test_gaps_backpressure();
    logic [23:0] exp_sum;
    exp_sum = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      prod_valid = (i % 2 == 0);
      prod_in    = 16'($urandom);
      if (prod_valid) exp_sum = exp_sum + 24'(prod_in);
      step();
      if (i < 6) begin
        checks++;
        if ({a_busy, a_valid} !== 2'b10) begin
          errors++; $display("FAIL gaps_busy step %0d got %b exp 10", i, {a_busy, a_valid});
        end
      end
    end
    // Keep offering a product while the result is held; it must be refused.
    prod_valid = 1'b1;
    prod_in    = 16'hFFFF;
    acc_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({a_valid, a_ready} !== 2'b10 || a_out !== exp_sum) begin
        errors++; $display("FAIL gaps_hold cycle %0d got v%b r%b %h exp v1 r0 %h",
                           i, a_valid, a_ready, a_out, exp_sum);
      end
      step();
    end
    prod_valid = 1'b0;
    acc_ready  = 1'b1;
    step();
    acc_ready = 1'b0;
    checks++;
    if ({a_valid, a_ready, a_busy} !== 3'b010) begin
      errors++; $display("FAIL gaps_idle got %b exp 010", {a_valid, a_ready, a_busy});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    prod_valid = 1'b1;
    prod_in    = 16'hFE01;
    for (int i = 0; i < 4; i++) step();
    prod_valid = 1'b0;
    checks++;
    if (c_out !== 17'h1F804 || {c_valid, c_ovf} !== 2'b11) begin
      errors++; $display("FAIL ovf_wrap got %h v%b o%b exp 1f804 v1 o1", c_out, c_valid, c_ovf);
    end
    checks++;
    if (d_out !== 17'h1FFFF || {d_valid, d_ovf} !== 2'b11) begin
      errors++; $display("FAIL ovf_sat got %h v%b o%b exp 1ffff v1 o1", d_out, d_valid, d_ovf);
    end
    checks++;
    if (a_out !== 24'h03F804 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_wide got %h o%b exp 03f804 o0", a_out, a_ovf);
    end
    // The next result starts with the flag cleared.
    acc_ready = 1'b1;
    step();
    acc_ready  = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 16'h0001;
    for (int i = 0; i < 4; i++) step();
    prod_valid = 1'b0;
    checks++;
    if (c_out !== 17'h4 || c_ovf !== 1'b0 || d_out !== 17'h4 || d_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_next got c %h o%b d %h o%b exp 4 o0", c_out, c_ovf, d_out, d_ovf);
    end
  endtask

  task automatic test_clear();
    do_reset();
    prod_valid = 1'b1;
    prod_in    = 16'h1234;
    for (int i = 0; i < 3; i++) step();
    clear   = 1'b1;
    prod_in = 16'h5555;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++; $display("FAIL clear_ready_same_cycle got %b exp 1", b_ready);
    end
    step();
    clear = 1'b0;
    checks++;
    if ({b_busy, b_valid, b_ready} !== 3'b001) begin
      errors++; $display("FAIL clear_idle got %b exp 001", {b_busy, b_valid, b_ready});
    end
    prod_in = 16'h0001;
    for (int i = 0; i < 8; i++) step();
    prod_valid = 1'b0;
    checks++;
    if (b_out !== 24'h000008 || {b_valid, b_ovf} !== 2'b10) begin
      errors++; $display("FAIL clear_sum got %h v%b o%b exp 000008 v1 o0", b_out, b_valid, b_ovf);
    end
    checks++;
    if (a_out !== 24'h000004 || a_valid !== 1'b1) begin
      errors++; $display("FAIL clear_a_held got %h v%b exp 000004 v1", a_out, a_valid);
    end
    // Clearing a held result discards it.
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({a_valid, a_ready, b_valid, b_ready} !== 4'b0101) begin
      errors++; $display("FAIL clear_done got %b exp 0101", {a_valid, a_ready, b_valid, b_ready});
    end
  endtask

  task automatic test_reset_in_done();
    do_reset();
    prod_valid = 1'b1;
    prod_in    = 16'hFE01;
    for (int i = 0; i < 4; i++) step();
    prod_valid = 1'b0;
    checks++;
    if ({c_valid, c_ovf} !== 2'b11) begin
      errors++; $display("FAIL rst_done_pre got %b exp 11", {c_valid, c_ovf});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({c_valid, c_ready, c_ovf, c_busy} !== 4'b0100 ||
        {a_valid, a_ready, a_ovf, a_busy} !== 4'b0100) begin
      errors++; $display("FAIL rst_done got c %b a %b exp 0100",
                         {c_valid, c_ready, c_ovf, c_busy}, {a_valid, a_ready, a_ovf, a_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] held;
    bit          exp_valid;
    held      = '0;
    exp_valid = 1'b0;
    do_reset();
    prod_valid = 1'b1;
    acc_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      prod_in = 16'($urandom);
      checks++;
      if (e_valid !== exp_valid || (exp_valid && e_out !== 24'(held))) begin
        errors++; $display("FAIL b2b cycle %0d got v%b %h exp v%b %h",
                           i, e_valid, e_out, exp_valid, 24'(held));
      end
      // A LEN=1 result fills on one cycle and drains on the next.
      if (!exp_valid) begin
        held      = prod_in;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      step();
    end
    idle_inputs();
  endtask

  // Reference: a result is the plain integer total of the LEN accepted terms;
  // the wrapped value, clamp and overflow flag all follow from that total.
  task automatic test_random();
    bit              pending;
    int              n;
    longint unsigned total;
    pending = 1'b0;
    n       = 0;
    total   = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_in    = 16'($urandom);
      acc_ready  = ($urandom_range(0, 2) == 0);
      clear      = ($urandom_range(0, 60) == 0);

      checks++;
      if ({a_ready, a_valid, a_busy} !== {!pending, pending, (!pending && n > 0)}) begin
        errors++; $display("FAIL rand_flags cycle %0d got %b exp %b", cyc,
                           {a_ready, a_valid, a_busy}, {!pending, pending, (!pending && n > 0)});
      end
      if (pending) begin
        checks++;
        if (a_out !== 24'(total) || a_ovf !== (total >= 64'd16777216)) begin
          errors++; $display("FAIL rand_a cycle %0d got %h o%b exp %h", cyc, a_out, a_ovf, 24'(total));
        end
        checks++;
        if (c_out !== 17'(total) || c_ovf !== (total >= 64'd131072)) begin
          errors++; $display("FAIL rand_wrap cycle %0d got %h o%b exp %h o%b", cyc, c_out, c_ovf,
                             17'(total), (total >= 64'd131072));
        end
        checks++;
        if (d_out !== ((total >= 64'd131072) ? 17'h1FFFF : 17'(total)) ||
            d_ovf !== (total >= 64'd131072)) begin
          errors++; $display("FAIL rand_sat cycle %0d got %h o%b total %h", cyc, d_out, d_ovf, total);
        end
      end

      if (clear) begin
        pending = 1'b0;
        n       = 0;
        total   = 0;
      end else if (!pending && prod_valid) begin
        total = total + 64'(prod_in);
        n++;
        if (n == 4) pending = 1'b1;
      end else if (pending && acc_ready) begin
        pending = 1'b0;
        n       = 0;
        total   = 0;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic_sum();
    test_gaps_backpressure();
    test_overflow();
    test_clear();
    test_reset_in_done();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
